// File: rtl/axis_frame_buffer.sv
// Two-slot frame conditioner: slices an AXIS char stream into N-char frames, padding short packets and truncating long ones.
// Output valid 1 cycle after a slot commits; input stalls only when both slots hold unsent frames.
module axis_frame_buffer #(
  parameter int                  CHAR_LEN = 8,
  parameter int                  N        = 10,
  parameter logic [CHAR_LEN-1:0] PAD_CHAR = '0
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [CHAR_LEN-1:0] S_AXIS_TDATA,
  input  logic                S_AXIS_TLAST,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  output logic [CHAR_LEN-1:0] M_AXIS_TDATA,
  output logic                M_AXIS_TLAST,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  input  logic                err_clr,
  output logic                err_short,
  output logic                err_long,
  output logic [15:0]         frame_cnt,
  output logic [1:0]          occupancy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(N + 1);
  localparam logic [LW-1:0] LAST_IDX = LW'(N - 1);
  localparam logic [LW-1:0] FULL_LEN = LW'(N);

  typedef enum logic {
    W_FILL = 1'b0,
    W_DROP = 1'b1
  } wstate_t;

  wstate_t             state_q, state_d;
  logic                wsel_q, wsel_d;
  logic                rsel_q, rsel_d;
  logic [LW-1:0]       wcnt_q, wcnt_d;
  logic [LW-1:0]       rcnt_q, rcnt_d;
  logic [1:0]          valid_q, valid_d;
  logic [1:0][LW-1:0]  len_q, len_d;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [CHAR_LEN-1:0] mem_q [2][N];

  logic s_hs;
  logic m_hs;
  logic wr_en;

  // A slot released this cycle is only seen as free after the edge, since TREADY reads registered valid.
  assign S_AXIS_TREADY = ARESETN & ((state_q == W_DROP) | ~valid_q[wsel_q]);
  assign s_hs          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign m_hs          = valid_q[rsel_q] & M_AXIS_TREADY;
  assign wr_en         = s_hs & (state_q == W_FILL);

  assign M_AXIS_TVALID = valid_q[rsel_q];
  assign M_AXIS_TLAST  = (rcnt_q == LAST_IDX);
  assign M_AXIS_TDATA  = (rcnt_q < len_q[rsel_q]) ? mem_q[rsel_q][rcnt_q[CW-1:0]] : PAD_CHAR;

  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign frame_cnt = frame_cnt_q;
  assign occupancy = {1'b0, valid_q[0]} + {1'b0, valid_q[1]};

  always_comb begin
    state_d     = state_q;
    wsel_d      = wsel_q;
    rsel_d      = rsel_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    valid_d     = valid_q;
    len_d       = len_q;
    frame_cnt_d = frame_cnt_q;
    // Clear first so an error raised in the same cycle overrides it.
    err_short_d = err_short_q & ~err_clr;
    err_long_d  = err_long_q & ~err_clr;

    case (state_q)
      W_FILL: begin
        if (s_hs) begin
          if (wcnt_q == LAST_IDX) begin
            valid_d[wsel_q] = 1'b1;
            len_d[wsel_q]   = FULL_LEN;
            wsel_d          = ~wsel_q;
            wcnt_d          = '0;
            if (!S_AXIS_TLAST) begin
              err_long_d = 1'b1;
              state_d    = W_DROP;
            end
          end else if (S_AXIS_TLAST) begin
            valid_d[wsel_q] = 1'b1;
            len_d[wsel_q]   = wcnt_q + 1'b1;
            wsel_d          = ~wsel_q;
            wcnt_d          = '0;
            err_short_d     = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      W_DROP: begin
        if (s_hs && S_AXIS_TLAST) state_d = W_FILL;
      end
      default: state_d = W_FILL;
    endcase

    // Commit only targets a slot with valid=0, release only one with valid=1, so they never collide.
    if (m_hs) begin
      if (rcnt_q == LAST_IDX) begin
        valid_d[rsel_q] = 1'b0;
        rsel_d          = ~rsel_q;
        rcnt_d          = '0;
        frame_cnt_d     = frame_cnt_q + 16'd1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= W_FILL;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      valid_q     <= '0;
      len_q       <= {2{FULL_LEN}};
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      valid_q     <= valid_d;
      len_q       <= len_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_en) mem_q[wsel_q][wcnt_q[CW-1:0]] <= S_AXIS_TDATA;
  end

endmodule

// File: tb/tb_axis_frame_buffer.sv
// Directed bench for axis_frame_buffer (N=10, PAD_CHAR=0): exact, short, long, full, random-stall and mid-frame reset.
module tb_axis_frame_buffer;

  localparam int N = 10;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [7:0]  S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic [7:0]  M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        err_clr;
  logic        err_short;
  logic        err_long;
  logic [15:0] frame_cnt;
  logic [1:0]  occupancy;

  always #5 ACLK = ~ACLK;

  axis_frame_buffer #(.CHAR_LEN(8), .N(N), .PAD_CHAR(8'h00)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .err_clr(err_clr), .err_short(err_short), .err_long(err_long),
    .frame_cnt(frame_cnt), .occupancy(occupancy)
  );

  int         total = 0;
  int         bad = 0;
  int         acc_cnt = 0;
  int         s_stalls = 0;
  bit         rnd_mode = 0;
  bit         chk_en = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_dat;
  logic       prev_last;
  logic       last_mvld;
  logic [8:0] in_q[$];
  logic [8:0] out_q[$];

  task automatic drive(input bit hold);
    if (rnd_mode) M_AXIS_TREADY = 1'($urandom_range(0, 1));
    if (!hold) begin
      if (in_q.size() > 0 && !(rnd_mode && $urandom_range(0, 3) == 0)) begin
        S_AXIS_TVALID = 1'b1;
        {S_AXIS_TLAST, S_AXIS_TDATA} = in_q[0];
      end else begin
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, then drive #1 after the rising edge.
  task automatic step();
    bit s_acc;
    @(negedge ACLK);
    s_acc = ARESETN && S_AXIS_TVALID && S_AXIS_TREADY;
    if (S_AXIS_TVALID && !S_AXIS_TREADY) s_stalls++;
    last_mvld = M_AXIS_TVALID;
    if (ARESETN && M_AXIS_TVALID && M_AXIS_TREADY) out_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
    if (chk_en) begin
      total++;
      if (occupancy > 2'd2) begin
        bad++; $display("FAIL occupancy_max: got %0d want <=2", occupancy);
      end
      if (prev_stall) begin
        total++;
        if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== prev_dat || M_AXIS_TLAST !== prev_last) begin
          bad++;
          $display("FAIL stall_hold: got vld=%0b dat=%02h last=%0b want vld=1 dat=%02h last=%0b",
                   M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, prev_dat, prev_last);
        end
      end
    end
    prev_stall = ARESETN && M_AXIS_TVALID && !M_AXIS_TREADY;
    prev_dat   = M_AXIS_TDATA;
    prev_last  = M_AXIS_TLAST;
    @(posedge ACLK); #1;
    if (s_acc) begin
      void'(in_q.pop_front());
      acc_cnt++;
    end
    drive(S_AXIS_TVALID && !s_acc);
  endtask

  task automatic drain(input int n, input int bound);
    int k = 0;
    while ((out_q.size() < n || in_q.size() > 0) && k < bound) begin
      step();
      k++;
    end
    if (k >= bound) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d beats want %0d", out_q.size(), n);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; err_clr = 1'b0; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
    S_AXIS_TDATA = '0; M_AXIS_TREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    total++; if (S_AXIS_TREADY !== 1'b0) begin bad++; $display("FAIL rst_tready_low: got %0b want 0", S_AXIS_TREADY); end
    ARESETN = 1'b1;
    #1;
    total++; if (S_AXIS_TREADY !== 1'b1) begin bad++; $display("FAIL rst_tready_after: got %0b want 1", S_AXIS_TREADY); end
    total++; if (M_AXIS_TVALID !== 1'b0) begin bad++; $display("FAIL rst_mvalid: got %0b want 0", M_AXIS_TVALID); end
    total++; if (M_AXIS_TLAST !== 1'b0) begin bad++; $display("FAIL rst_mlast: got %0b want 0", M_AXIS_TLAST); end
    total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("FAIL rst_err: got %02b want 00", {err_short, err_long}); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
    chk_en = 1;
  endtask

  task automatic test_exact();
    logic [8:0] exp_q[$];
    int k = 0;
    out_q.delete();
    M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_q.push_back({i == N - 1, 8'(8'h41 + i)});
      exp_q.push_back({i == N - 1, 8'(8'h41 + i)});
    end
    drive(1'b0);
    while (in_q.size() > 0 && k < 100) begin step(); k++; end
    total++; if (last_mvld !== 1'b0) begin bad++; $display("FAIL exact_vld_before: got %0b want 0", last_mvld); end
    total++; if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== 8'h41) begin
      bad++; $display("FAIL exact_first_out: got vld=%0b dat=%02h want vld=1 dat=41", M_AXIS_TVALID, M_AXIS_TDATA);
    end
    drain(N, 200);
    total++; if (out_q.size() != exp_q.size()) begin bad++; $display("FAIL exact_len: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL exact_beat%0d: got %03h want %03h", i, out_q[i], exp_q[i]); end
    end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL exact_frame_cnt: got %0d want 1", frame_cnt); end
    total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("FAIL exact_err: got %02b want 00", {err_short, err_long}); end
  endtask

  task automatic test_short();
    logic [8:0] exp_q[$];
    out_q.delete();
    for (int i = 0; i < 4; i++) in_q.push_back({i == 3, 8'(8'h61 + i)});
    for (int i = 0; i < N; i++) exp_q.push_back({i == N - 1, (i < 4) ? 8'(8'h61 + i) : 8'h00});
    drive(1'b0);
    drain(N, 200);
    total++; if (out_q.size() != exp_q.size()) begin bad++; $display("FAIL short_len: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL short_beat%0d: got %03h want %03h", i, out_q[i], exp_q[i]); end
    end
    total++; if (err_short !== 1'b1 || err_long !== 1'b0) begin bad++; $display("FAIL short_err: got s=%0b l=%0b want s=1 l=0", err_short, err_long); end
    total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL short_frame_cnt: got %0d want 2", frame_cnt); end
    pulse_clr();
    total++; if (err_short !== 1'b0) begin bad++; $display("FAIL short_clr: got %0b want 0", err_short); end
  endtask

  task automatic test_long();
    logic [8:0] exp_q[$];
    out_q.delete();
    s_stalls = 0;
    acc_cnt = 0;
    for (int i = 0; i < 13; i++) in_q.push_back({i == 12, 8'(i + 1)});
    for (int i = 0; i < N; i++) in_q.push_back({i == N - 1, 8'(8'h20 + i)});
    for (int i = 0; i < N; i++) exp_q.push_back({i == N - 1, 8'(i + 1)});
    for (int i = 0; i < N; i++) exp_q.push_back({i == N - 1, 8'(8'h20 + i)});
    drive(1'b0);
    drain(2 * N, 300);
    total++; if (s_stalls != 0 || acc_cnt != 23) begin bad++; $display("FAIL long_accept: got stalls=%0d acc=%0d want stalls=0 acc=23", s_stalls, acc_cnt); end
    total++; if (out_q.size() != exp_q.size()) begin bad++; $display("FAIL long_len: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL long_beat%0d: got %03h want %03h", i, out_q[i], exp_q[i]); end
    end
    total++; if (err_long !== 1'b1 || err_short !== 1'b0) begin bad++; $display("FAIL long_err: got s=%0b l=%0b want s=0 l=1", err_short, err_long); end
    total++; if (frame_cnt !== 16'd4) begin bad++; $display("FAIL long_frame_cnt: got %0d want 4", frame_cnt); end
    pulse_clr();
    total++; if (err_long !== 1'b0) begin bad++; $display("FAIL long_clr: got %0b want 0", err_long); end
  endtask

  task automatic test_full();
    logic [8:0] exp_q[$];
    out_q.delete();
    acc_cnt = 0;
    M_AXIS_TREADY = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) begin
        in_q.push_back({i == N - 1, 8'(8'h80 + 10 * f + i)});
        exp_q.push_back({i == N - 1, 8'(8'h80 + 10 * f + i)});
      end
    drive(1'b0);
    repeat (40) step();
    total++; if (acc_cnt != 20) begin bad++; $display("FAIL full_accepted: got %0d want 20", acc_cnt); end
    total++; if (S_AXIS_TREADY !== 1'b0) begin bad++; $display("FAIL full_tready: got %0b want 0", S_AXIS_TREADY); end
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL full_occupancy: got %0d want 2", occupancy); end
    total++; if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== 8'h80 || M_AXIS_TLAST !== 1'b0) begin
      bad++; $display("FAIL full_head: got vld=%0b dat=%02h last=%0b want vld=1 dat=80 last=0", M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST);
    end
    M_AXIS_TREADY = 1'b1;
    drain(3 * N, 300);
    total++; if (out_q.size() != exp_q.size()) begin bad++; $display("FAIL full_len: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_beat%0d: got %03h want %03h", i, out_q[i], exp_q[i]); end
    end
    total++; if (frame_cnt !== 16'd7) begin bad++; $display("FAIL full_frame_cnt: got %0d want 7", frame_cnt); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL full_drained_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    bit any_short = 0;
    bit any_long = 0;
    int len;
    out_q.delete();
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 14);
      if (len < N) any_short = 1;
      if (len > N) any_long = 1;
      for (int i = 0; i < len; i++) in_q.push_back({i == len - 1, 8'(p * 17 + i + 1)});
      for (int i = 0; i < N; i++) exp_q.push_back({i == N - 1, (i < len) ? 8'(p * 17 + i + 1) : 8'h00});
    end
    rnd_mode = 1;
    drive(1'b0);
    drain(40 * N, 5000);
    rnd_mode = 0;
    M_AXIS_TREADY = 1'b1;
    total++; if (out_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_len: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat%0d: got %03h want %03h", i, out_q[i], exp_q[i]); end
    end
    total++; if (frame_cnt !== 16'd47) begin bad++; $display("FAIL rand_frame_cnt: got %0d want 47", frame_cnt); end
    total++; if (err_short !== any_short || err_long !== any_long) begin
      bad++; $display("FAIL rand_err: got s=%0b l=%0b want s=%0b l=%0b", err_short, err_long, any_short, any_long);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp_q[$];
    int k = 0;
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < N; i++) in_q.push_back({i == N - 1, 8'(8'hA0 + i)});
    for (int i = 0; i < 3; i++) in_q.push_back({1'b0, 8'(8'hB0 + i)});
    drive(1'b0);
    while (in_q.size() > 0 && k < 100) begin step(); k++; end
    out_q.delete();
    M_AXIS_TREADY = 1'b1;
    repeat (5) step();
    total++; if (out_q.size() != 5) begin bad++; $display("FAIL mid_beats_before: got %0d want 5", out_q.size()); end
    ARESETN = 1'b0;
    M_AXIS_TREADY = 1'b0;
    #1;
    total++; if (S_AXIS_TREADY !== 1'b0) begin bad++; $display("FAIL mid_tready_in_rst: got %0b want 0", S_AXIS_TREADY); end
    step();
    ARESETN = 1'b1;
    #1;
    total++; if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0) begin
      bad++; $display("FAIL mid_out_rst: got vld=%0b last=%0b want 0 0", M_AXIS_TVALID, M_AXIS_TLAST);
    end
    total++; if (occupancy !== 2'd0 || frame_cnt !== 16'd0) begin
      bad++; $display("FAIL mid_state_rst: got occ=%0d cnt=%0d want 0 0", occupancy, frame_cnt);
    end
    total++; if (S_AXIS_TREADY !== 1'b1 || {err_short, err_long} !== 2'b00) begin
      bad++; $display("FAIL mid_flags_rst: got rdy=%0b err=%02b want rdy=1 err=00", S_AXIS_TREADY, {err_short, err_long});
    end
    out_q.delete();
    M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_q.push_back({i == N - 1, 8'(8'hC0 + i)});
      exp_q.push_back({i == N - 1, 8'(8'hC0 + i)});
    end
    drive(1'b0);
    drain(N, 200);
    total++; if (out_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_len: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_beat%0d: got %03h want %03h", i, out_q[i], exp_q[i]); end
    end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL mid_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_short();
    test_long();
    test_full();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
